// File: rtl/jpeg_enc_pkg.sv
// jpeg_enc_pkg: shared pixel-block constants and ping-pong buffer state types
package jpeg_enc_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int NUM_PIX = 64;
  typedef enum logic [1:0] {BUF_FREE, BUF_FILL, BUF_FULL} buf_state_e;
  typedef logic buf_idx_t;
endpackage

// File: rtl/jpeg_buf_state.sv
// jpeg_buf_state: per-buffer FREE/FILL/FULL state register
// Ports: set_fill_i (pixel accepted), set_full_i (last pixel accepted),
//        release_i (block consumed downstream), state_o (current state)
module jpeg_buf_state
  import jpeg_enc_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       set_fill_i,
  input  logic       set_full_i,
  input  logic       release_i,
  output buf_state_e state_o
);
  buf_state_e state_q, state_d;
  always_comb state_d = release_i ? BUF_FREE : set_full_i ? BUF_FULL : set_fill_i ? BUF_FILL : state_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= BUF_FREE;
    else state_q <= state_d;
  assign state_o = state_q;
endmodule

// File: rtl/jpeg_block_fill_ctrl.sv
// jpeg_block_fill_ctrl: ping-pong fill controller for two pixel block buffers
// Ports: pix_valid_i/pix_ready_o/pix_data_i upstream raster stream;
//        buf_wr_en_o/buf_wr_data_o one-hot registered buffer write;
//        blk_valid_o/blk_sel_o/blk_ready_i completed-block offer to DCT;
//        fill_level_o pixels in current fill buffer; blk_count_o delivered blocks
module jpeg_block_fill_ctrl #(
  parameter int DATA_WIDTH = jpeg_enc_pkg::DATA_WIDTH,
  parameter int NUM_PIX    = jpeg_enc_pkg::NUM_PIX,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       pix_valid_i,
  output logic                       pix_ready_o,
  input  logic [DATA_WIDTH-1:0]      pix_data_i,
  output logic [1:0]                 buf_wr_en_o,
  output logic [DATA_WIDTH-1:0]      buf_wr_data_o,
  output logic                       blk_valid_o,
  output logic                       blk_sel_o,
  input  logic                       blk_ready_i,
  output logic [$clog2(NUM_PIX)-1:0] fill_level_o,
  output logic [CNT_WIDTH-1:0]       blk_count_o
);
  import jpeg_enc_pkg::*;
  localparam int FW = $clog2(NUM_PIX);
  buf_state_e st [2];
  buf_idx_t wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [1:0] wr_en_q, wr_en_d, set_fill, set_full, rel;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic accept, last, take;
  assign pix_ready_o = st[wr_sel_q] != BUF_FULL;
  assign accept = pix_valid_i & pix_ready_o;
  assign last = fill_q == FW'(NUM_PIX - 1);
  // the offer waits until the final pixel has landed in the buffer
  assign blk_valid_o = st[rd_sel_q] == BUF_FULL && !wr_en_q[rd_sel_q];
  assign take = blk_valid_o & blk_ready_i;
  always_comb begin
    wr_en_d   = accept ? 2'b01 << wr_sel_q : 2'b00;
    wr_data_d = accept ? pix_data_i : wr_data_q;
    fill_d    = accept ? (last ? '0 : fill_q + 1'b1) : fill_q;
    wr_sel_d  = wr_sel_q ^ (accept & last);
    rd_sel_d  = rd_sel_q ^ take;
    cnt_d     = cnt_q + CNT_WIDTH'(take);
    set_fill  = {2{accept & ~last}} & wr_en_d;
    set_full  = {2{accept & last}} & wr_en_d;
    rel       = {2{take}} & (2'b01 << rd_sel_q);
  end
  for (genvar i = 0; i < 2; i++) begin : g_buf
    jpeg_buf_state u_state (
      .clock      (clock),
      .reset_n    (reset_n),
      .set_fill_i (set_fill[i]),
      .set_full_i (set_full[i]),
      .release_i  (rel[i]),
      .state_o    (st[i])
    );
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_sel_q  <= '0;
      rd_sel_q  <= '0;
      fill_q    <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      fill_q    <= fill_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  assign buf_wr_en_o   = wr_en_q;
  assign buf_wr_data_o = wr_data_q;
  assign blk_sel_o     = rd_sel_q;
  assign fill_level_o  = fill_q;
  assign blk_count_o   = cnt_q;
endmodule

// File: tb/tb_jpeg_block_fill_ctrl.sv
// tb_jpeg_block_fill_ctrl: directed self-checking bench with a two-buffer memory model
module tb_jpeg_block_fill_ctrl;
  logic clock = 0, reset_n = 1;
  logic pix_valid = 0, blk_ready = 0;
  logic [11:0] pix_data = 0;
  logic pix_ready, blk_valid, blk_sel;
  logic [1:0] buf_wr_en;
  logic [11:0] buf_wr_data;
  logic [5:0] fill_level;
  logic [15:0] blk_count;
  int checks = 0, failures = 0;
  logic [11:0] mem [2][64];
  int ptr [2] = '{0, 0};
  always #5 clock = ~clock;
  jpeg_block_fill_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pix_valid_i   (pix_valid),
    .pix_ready_o   (pix_ready),
    .pix_data_i    (pix_data),
    .buf_wr_en_o   (buf_wr_en),
    .buf_wr_data_o (buf_wr_data),
    .blk_valid_o   (blk_valid),
    .blk_sel_o     (blk_sel),
    .blk_ready_i   (blk_ready),
    .fill_level_o  (fill_level),
    .blk_count_o   (blk_count)
  );
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ptr[0] <= 0;
      ptr[1] <= 0;
    end else
      for (int b = 0; b < 2; b++)
        if (buf_wr_en[b]) begin
          mem[b][ptr[b]] <= buf_wr_data;
          ptr[b] <= (ptr[b] + 1) % 64;
        end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    pix_valid = 0;
    blk_ready = 0;
    pix_data = 0;
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask
  task automatic test_reset();
    reset_n = 0;
    tick();
    checks++;
    if (pix_ready !== 1'b1 || buf_wr_en !== 2'b00 || buf_wr_data !== 12'd0) begin
      failures++;
      $display("FAIL reset_wr ready=%b wr_en=%b data=%0d exp 1/00/0", pix_ready, buf_wr_en, buf_wr_data);
    end
    checks++;
    if (blk_valid !== 1'b0 || blk_sel !== 1'b0 || fill_level !== 6'd0 || blk_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_blk valid=%b sel=%b fill=%0d count=%0d exp 0/0/0/0", blk_valid, blk_sel, fill_level, blk_count);
    end
    reset_n = 1;
  endtask
  task automatic test_fill();
    int bad;
    do_reset();
    for (int i = 0; i < 128; i++) begin
      pix_valid = 1;
      pix_data = 12'(i);
      tick();
      checks++;
      if (buf_wr_en !== (i < 64 ? 2'b01 : 2'b10) || buf_wr_data !== 12'(i)) begin
        failures++;
        $display("FAIL fill_wr[%0d] wr_en=%b data=%0d exp_data=%0d", i, buf_wr_en, buf_wr_data, i);
      end
      checks++;
      if (fill_level !== 6'((i + 1) % 64)) begin
        failures++;
        $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, fill_level, (i + 1) % 64);
      end
      if (i == 63) begin
        checks++;
        if (blk_valid !== 1'b0 || pix_ready !== 1'b1) begin
          failures++;
          $display("FAIL fill_pending valid=%b ready=%b exp 0/1", blk_valid, pix_ready);
        end
      end
      if (i == 64) begin
        checks++;
        if (blk_valid !== 1'b1 || blk_sel !== 1'b0 || pix_ready !== 1'b1) begin
          failures++;
          $display("FAIL fill_offer_a valid=%b sel=%b ready=%b exp 1/0/1", blk_valid, blk_sel, pix_ready);
        end
      end
    end
    checks++;
    if (pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL both_full_ready got=%b exp=0", pix_ready);
    end
    pix_data = 12'd128;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (buf_wr_en !== 2'b00 || fill_level !== 6'd0 || pix_ready !== 1'b0 || blk_valid !== 1'b1 || blk_sel !== 1'b0) begin
      failures++;
      $display("FAIL stall wr_en=%b fill=%0d ready=%b valid=%b sel=%b exp 00/0/0/1/0", buf_wr_en, fill_level, pix_ready, blk_valid, blk_sel);
    end
    bad = 0;
    for (int j = 0; j < 64; j++) if (mem[0][j] !== 12'(j) || mem[1][j] !== 12'(64 + j)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fill_contents bad_words=%0d exp=0", bad);
    end
    blk_ready = 1;
    tick();
    blk_ready = 0;
    checks++;
    if (blk_count !== 16'd1 || blk_sel !== 1'b1 || blk_valid !== 1'b1 || pix_ready !== 1'b1 || buf_wr_en !== 2'b00) begin
      failures++;
      $display("FAIL release_a count=%0d sel=%b valid=%b ready=%b wr_en=%b exp 1/1/1/1/00", blk_count, blk_sel, blk_valid, pix_ready, buf_wr_en);
    end
    tick();
    checks++;
    if (buf_wr_en !== 2'b01 || buf_wr_data !== 12'd128 || fill_level !== 6'd1) begin
      failures++;
      $display("FAIL held_pixel wr_en=%b data=%0d fill=%0d exp 01/128/1", buf_wr_en, buf_wr_data, fill_level);
    end
    for (int i = 1; i < 64; i++) begin
      pix_data = 12'(128 + i);
      blk_ready = (i == 63);
      tick();
    end
    blk_ready = 0;
    pix_valid = 0;
    checks++;
    if (blk_count !== 16'd2 || pix_ready !== 1'b1 || blk_sel !== 1'b0 || fill_level !== 6'd0 || blk_valid !== 1'b0 || buf_wr_en !== 2'b01) begin
      failures++;
      $display("FAIL same_edge count=%0d ready=%b sel=%b fill=%0d valid=%b wr_en=%b exp 2/1/0/0/0/01", blk_count, pix_ready, blk_sel, fill_level, blk_valid, buf_wr_en);
    end
    tick();
    checks++;
    if (blk_valid !== 1'b1 || blk_sel !== 1'b0 || buf_wr_en !== 2'b00) begin
      failures++;
      $display("FAIL same_edge_offer valid=%b sel=%b wr_en=%b exp 1/0/00", blk_valid, blk_sel, buf_wr_en);
    end
    bad = 0;
    for (int j = 0; j < 64; j++) if (mem[0][j] !== 12'(128 + j)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL refill_contents bad_words=%0d exp=0", bad);
    end
  endtask
  task automatic test_back_to_back();
    int sent = 0, nblk = 0, stall = 0, bad;
    do_reset();
    blk_ready = 1;
    for (int c = 0; c < 800 && (sent < 640 || nblk < 10); c++) begin
      pix_valid = sent < 640;
      pix_data = 12'(sent);
      if (blk_valid) begin
        checks++;
        if (blk_sel !== 1'(nblk % 2)) begin
          failures++;
          $display("FAIL b2b_sel[%0d] got=%b exp=%0d", nblk, blk_sel, nblk % 2);
        end
        bad = 0;
        for (int j = 0; j < 64; j++) if (mem[nblk % 2][j] !== 12'(nblk * 64 + j)) bad++;
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL b2b_block[%0d] bad_words=%0d exp=0", nblk, bad);
        end
        nblk++;
      end
      if (pix_valid && !pix_ready) stall++;
      if (pix_valid && pix_ready) sent++;
      tick();
    end
    blk_ready = 0;
    pix_valid = 0;
    checks++;
    if (stall != 0 || nblk != 10 || blk_count !== 16'd10) begin
      failures++;
      $display("FAIL b2b_summary stalls=%0d blocks=%0d count=%0d exp 0/10/10", stall, nblk, blk_count);
    end
  endtask
  task automatic test_gaps();
    int acc = 0, nblk = 0, bad, sel;
    bit took;
    do_reset();
    blk_ready = 1;
    for (int c = 0; c < 3000 && (acc < 128 || nblk < 2); c++) begin
      pix_valid = acc < 128 && $urandom_range(0, 9) < 3;
      pix_data = pix_valid ? 12'(1000 + acc) : 'x;
      if (blk_valid) begin
        bad = 0;
        for (int j = 0; j < 64; j++) if (mem[nblk % 2][j] !== 12'(1000 + nblk * 64 + j)) bad++;
        checks++;
        if (bad != 0 || blk_sel !== 1'(nblk % 2)) begin
          failures++;
          $display("FAIL gap_block[%0d] bad_words=%0d sel=%b exp 0/%0d", nblk, bad, blk_sel, nblk % 2);
        end
        nblk++;
      end
      took = pix_valid && pix_ready;
      sel = (acc / 64) % 2;
      if (took) acc++;
      tick();
      checks++;
      if (fill_level !== 6'(acc % 64)) begin
        failures++;
        $display("FAIL gap_fill[%0d] got=%0d exp=%0d", c, fill_level, acc % 64);
      end
      checks++;
      if (buf_wr_en !== (took ? (sel == 1 ? 2'b10 : 2'b01) : 2'b00)) begin
        failures++;
        $display("FAIL gap_wr_en[%0d] got=%b took=%0d sel=%0d", c, buf_wr_en, took, sel);
      end
      if (acc > 0) begin
        checks++;
        if (buf_wr_data !== 12'(1000 + acc - 1)) begin
          failures++;
          $display("FAIL gap_data[%0d] got=%h exp=%0d", c, buf_wr_data, 1000 + acc - 1);
        end
      end
    end
    pix_valid = 0;
    pix_data = 0;
    blk_ready = 0;
    checks++;
    if (acc != 128 || nblk != 2) begin
      failures++;
      $display("FAIL gap_timeout accepts=%0d blocks=%0d exp 128/2", acc, nblk);
    end
  endtask
  task automatic test_reset_mid();
    int bad;
    do_reset();
    for (int i = 0; i < 128; i++) begin
      pix_valid = 1;
      pix_data = 12'(i);
      tick();
    end
    pix_valid = 0;
    blk_ready = 1;
    tick();
    blk_ready = 0;
    for (int i = 0; i < 37; i++) begin
      pix_valid = 1;
      pix_data = 12'(300 + i);
      tick();
    end
    pix_valid = 0;
    checks++;
    if (fill_level !== 6'd37 || pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_fill fill=%0d ready=%b exp 37/1", fill_level, pix_ready);
    end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (pix_ready !== 1'b1 || buf_wr_en !== 2'b00 || buf_wr_data !== 12'd0 || blk_valid !== 1'b0 ||
        blk_sel !== 1'b0 || fill_level !== 6'd0 || blk_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset ready=%b wr_en=%b data=%0d valid=%b sel=%b fill=%0d count=%0d exp reset values",
               pix_ready, buf_wr_en, buf_wr_data, blk_valid, blk_sel, fill_level, blk_count);
    end
    tick();
    reset_n = 1;
    for (int i = 0; i < 64; i++) begin
      pix_valid = 1;
      pix_data = 12'(500 + i);
      tick();
    end
    pix_valid = 0;
    tick();
    bad = 0;
    for (int j = 0; j < 64; j++) if (mem[0][j] !== 12'(500 + j)) bad++;
    checks++;
    if (bad != 0 || blk_valid !== 1'b1 || blk_sel !== 1'b0 || blk_count !== 16'd0) begin
      failures++;
      $display("FAIL post_reset_block bad_words=%0d valid=%b sel=%b count=%0d exp 0/1/0/0", bad, blk_valid, blk_sel, blk_count);
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
